frame_buf_arbiter: RTL
======================

# frame_buf_arbiter

Parametrised multi-buffer frame arbiter between one frame writer (camera/pattern source) and one frame reader (VGA scan-out) sharing the SDRAM controller's burst-load interface. It owns NBUF equal-size frame buffers in SDRAM and hands the writer a buffer the reader is not using. It points the reader at the newest completed frame, repeating the previous frame or dropping one when rates differ. It drives the controller's `wr_load`/`rd_load`/address/length inputs and consumes its `wr_done`/`rd_done` pulses.

## Interface
Parameters:
- `NBUF`, 2: number of frame buffers, legal 2..4.
- `ADDR_W`, 24: SDRAM word address width, {Bank, Row, Col}.
- `FRAME_LEN`, 1024*768: words per frame.
- `BASE_ADDR`, 24'h000000: address of buffer 0.
- `BUF_STRIDE`, 24'h100000: address distance between buffers.

Ports:
- `clk_sdram`  in  1  100 MHz controller clock; the block's only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `frm_wr_start`  in  1  writer requests a new frame (1-cycle pulse).
- `frm_rd_start`  in  1  reader requests a new frame (1-cycle pulse, e.g. vsync).
- `mcb_wr_done`  in  1  controller: current write burst sequence complete.
- `mcb_rd_done`  in  1  controller: current read sequence complete.
- `mcb_wr_load`  out  1  1-cycle pulse starting a frame write.
- `mcb_wr_addr`  out  ADDR_W  base address of the write buffer.
- `mcb_wr_length`  out  ADDR_W  constant FRAME_LEN-1 (0's based).
- `mcb_rd_load`  out  1  1-cycle pulse starting a frame read.
- `mcb_rd_addr`  out  ADDR_W  base address of the read buffer.
- `mcb_rd_length`  out  ADDR_W  constant FRAME_LEN-1.
- `mem_rdy`  out  1  at least one complete frame has been written.
- `wr_busy` / `rd_busy`  out  1  write / read sequence in flight.
- `wr_buf_idx` / `rd_buf_idx`  out  2  buffer currently owned by writer / reader.
- `drop_cnt`  out  16  frames overwritten before being read, saturating.
- `start_err`  out  1  sticky: a start arrived while the same side was busy.

## Operation
- Per-buffer state is implied by three registers: `rd_cur` (reader-held index), `latest` plus `latest_valid` (newest complete unread frame), and `wr_cur` with `wr_busy`.
- Event order within one cycle: done events first, then reader start, then writer start. All decisions use the updated values.
- `mcb_wr_done` with `wr_busy`=1: `latest`<=`wr_cur`, `latest_valid`<=1, `mem_rdy`<=1, `wr_busy`<=0. A done received while not busy is ignored. `mcb_rd_done` clears `rd_busy`, and `rd_cur` stays held.
- Reader start while `rd_busy`=0 and `mem_rdy`=1:
  - If `latest_valid` and `latest`!=`rd_cur`: `rd_cur`<=`latest` and `latest_valid`<=0.
  - Otherwise repeat `rd_cur`.
  - Either way, issue `mcb_rd_load` and set `rd_busy`.
  - A reader start while `mem_rdy`=0 is ignored, with no error.
- Writer start while `wr_busy`=0: candidates are all indices != `rd_cur`.
  - Choose the lowest candidate that is also != `latest` when `latest_valid`.
  - If no such candidate exists (only possible with NBUF=2), overwrite `latest`, clear `latest_valid`, and increment `drop_cnt` (saturate at 16'hFFFF).
  - Issue `mcb_wr_load` and set `wr_busy`.
- Start on a busy side: ignored, and `start_err`<=1 until reset.
- Address computation: addr = BASE_ADDR + idx*BUF_STRIDE, truncated to ADDR_W.
- `mcb_*_length` = FRAME_LEN-1, truncated to ADDR_W, constant.

## Timing
- Reset (rst_n=0 at an edge) sets:
  - `mcb_*_load`=0, `mcb_wr_addr`=`mcb_rd_addr`=BASE_ADDR.
  - `wr_busy`=`rd_busy`=0, `mem_rdy`=0.
  - `rd_cur`=`wr_cur`=`latest`=0, `latest_valid`=0.
  - `drop_cnt`=0, `start_err`=0.
- Because `rd_cur` resets to 0, the first write after reset targets buffer 1.
- Start sampled at edge t: `mcb_*_load` is high for exactly the cycle after t. Address, `*_buf_idx` and `*_busy` update at that same edge. Address holds until the next load.
- Done sampled at edge t: `*_busy` falls and `mem_rdy`/`latest` update after edge t. A new start at edge t+1 is accepted.
- A start in the same cycle as done on the same side is accepted, because done is processed first. This allows back-to-back frames with no idle cycle.
- A reader start in the same cycle as `mcb_wr_done` gets the just-completed buffer.
- Simultaneous reader and writer starts: the writer excludes the `rd_cur` value chosen in that cycle.
- Reset mid-sequence aborts all state immediately. The controller is reset with the same `rst_n`.

## Test plan
- NBUF=2, reset, `frm_wr_start` at cycle 5 -> `mcb_wr_load` high at cycle 6 only, `mcb_wr_addr`=24'h100000, length=786431, `mem_rdy`=0. Then `mcb_wr_done` -> `mem_rdy`=1 next cycle.
- Continuing: `frm_rd_start` -> `mcb_rd_load` with addr 24'h100000, `rd_buf_idx`=1. A second `frm_rd_start` after `mcb_rd_done`, with no new write -> repeat read of 24'h100000.
- Writer faster, NBUF=2:
  - Writes complete to buffer 0 while the reader holds 1.
  - The next `frm_wr_start` overwrites buffer 0 and `drop_cnt`=1.
  - A reader start during that write repeats buffer 1.
- NBUF=3, reader idle holding 0: three write frames -> buffers 1, 2, 1 with `drop_cnt` staying 0.
- `mcb_wr_done` (buffer 0) and `frm_rd_start` in the same cycle -> `mcb_rd_addr`=BASE_ADDR and `latest_valid` cleared. `frm_wr_start` on the same cycle as `mcb_wr_done` -> accepted with no gap.
- `frm_wr_start` while `wr_busy` -> no load and `start_err`=1. Assert `rst_n`=0 mid-write -> all outputs at reset values after one edge, and `start_err`=0.

Source files
------------

// File: rtl/frame_buf_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_buf_arbiter_if
// Description : Signal bundle between the frame buffer arbiter and its
//               surroundings: writer/reader start pulses, SDRAM controller
//               burst-load handshake and arbiter status.
//               master = environment (sources, controller), slave = arbiter.
// Revision    : 1.0  initial release
// ============================================================================
interface frame_buf_arbiter_if #(
    parameter int ADDR_W = 24
);
    // Frame source / scan-out requests
    logic              frm_wr_start;
    logic              frm_rd_start;

    // SDRAM controller burst-load handshake
    logic              mcb_wr_done;
    logic              mcb_rd_done;
    logic              mcb_wr_load;
    logic [ADDR_W-1:0] mcb_wr_addr;
    logic [ADDR_W-1:0] mcb_wr_length;
    logic              mcb_rd_load;
    logic [ADDR_W-1:0] mcb_rd_addr;
    logic [ADDR_W-1:0] mcb_rd_length;

    // Arbiter status
    logic              mem_rdy;
    logic              wr_busy;
    logic              rd_busy;
    logic [1:0]        wr_buf_idx;
    logic [1:0]        rd_buf_idx;
    logic [15:0]       drop_cnt;
    logic              start_err;

    modport master (
        output frm_wr_start, frm_rd_start, mcb_wr_done, mcb_rd_done,
        input  mcb_wr_load, mcb_wr_addr, mcb_wr_length,
        input  mcb_rd_load, mcb_rd_addr, mcb_rd_length,
        input  mem_rdy, wr_busy, rd_busy, wr_buf_idx, rd_buf_idx,
        input  drop_cnt, start_err
    );

    modport slave (
        input  frm_wr_start, frm_rd_start, mcb_wr_done, mcb_rd_done,
        output mcb_wr_load, mcb_wr_addr, mcb_wr_length,
        output mcb_rd_load, mcb_rd_addr, mcb_rd_length,
        output mem_rdy, wr_busy, rd_busy, wr_buf_idx, rd_buf_idx,
        output drop_cnt, start_err
    );
endinterface
`default_nettype wire

// File: rtl/frame_buf_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : frame_buf_arbiter
// Description : Multi-buffer frame arbiter between one frame writer and one
//               frame reader sharing an SDRAM controller. The writer always
//               gets a buffer the reader is not holding; the reader is pointed
//               at the newest completed frame, repeating or dropping frames
//               when the two rates differ.
// Revision    : 1.0  initial release
// ============================================================================
module frame_buf_arbiter #(
    parameter int                NBUF       = 2,
    parameter int                ADDR_W     = 24,
    parameter int                FRAME_LEN  = 1024*768,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 24'h000000,
    parameter logic [ADDR_W-1:0] BUF_STRIDE = 24'h100000
) (
    input  wire logic           clk_sdram,
    input  wire logic           rst_n,
    frame_buf_arbiter_if.slave  bus
);

    // Burst length handed to the controller is 0's based
    localparam logic [ADDR_W-1:0] c_frame_len_m1 = ADDR_W'(FRAME_LEN - 1);
    localparam logic [15:0]       c_drop_max     = 16'hFFFF;

    // Base address of buffer idx, wrapping within the address width
    function automatic logic [ADDR_W-1:0] f_buf_addr(input logic [1:0] idx);
        return BASE_ADDR + ADDR_W'(idx) * BUF_STRIDE;
    endfunction

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [1:0]        r_rd_cur;         // buffer held by the reader
    logic [1:0]        r_wr_cur;         // buffer being (or last) written
    logic [1:0]        r_latest;         // newest completed frame
    logic              r_latest_valid;   // r_latest not yet handed to reader
    logic              r_wr_busy;
    logic              r_rd_busy;
    logic              r_mem_rdy;
    logic              r_wr_load;
    logic              r_rd_load;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [15:0]       r_drop_cnt;
    logic              r_start_err;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    logic [1:0]        w_rd_cur;
    logic [1:0]        w_wr_cur;
    logic [1:0]        w_latest;
    logic              w_latest_valid;
    logic              w_wr_busy;
    logic              w_rd_busy;
    logic              w_mem_rdy;
    logic              w_wr_load;
    logic              w_rd_load;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [15:0]       w_drop_cnt;
    logic              w_start_err;
    logic [1:0]        w_pick;
    logic              w_found;

    // Resolve one cycle of events in order: completions, reader start, writer
    // start; every later step sees the values produced by the earlier ones.
    always_comb begin
        w_rd_cur       = r_rd_cur;
        w_wr_cur       = r_wr_cur;
        w_latest       = r_latest;
        w_latest_valid = r_latest_valid;
        w_wr_busy      = r_wr_busy;
        w_rd_busy      = r_rd_busy;
        w_mem_rdy      = r_mem_rdy;
        w_wr_load      = 1'b0;
        w_rd_load      = 1'b0;
        w_wr_addr      = r_wr_addr;
        w_rd_addr      = r_rd_addr;
        w_drop_cnt     = r_drop_cnt;
        w_start_err    = r_start_err;
        w_pick         = 2'd0;
        w_found        = 1'b0;

        // Completions: a finished write becomes the newest readable frame.
        // A stray write completion while idle carries no buffer and is dropped.
        if (bus.mcb_wr_done && r_wr_busy) begin
            w_latest       = r_wr_cur;
            w_latest_valid = 1'b1;
            w_mem_rdy      = 1'b1;
            w_wr_busy      = 1'b0;
        end
        if (bus.mcb_rd_done) begin
            w_rd_busy = 1'b0;
        end

        // Reader start: move to the newest frame if there is an unread one,
        // otherwise scan out the held buffer again.
        if (bus.frm_rd_start) begin
            if (w_rd_busy) begin
                w_start_err = 1'b1;
            end else if (w_mem_rdy) begin
                if (w_latest_valid && (w_latest != w_rd_cur)) begin
                    w_rd_cur       = w_latest;
                    w_latest_valid = 1'b0;
                end
                w_rd_load = 1'b1;
                w_rd_busy = 1'b1;
                w_rd_addr = f_buf_addr(w_rd_cur);
            end
        end

        // Writer start: lowest buffer neither held by the reader nor holding
        // an unread frame. Scanning high to low leaves the lowest match.
        if (bus.frm_wr_start) begin
            if (w_wr_busy) begin
                w_start_err = 1'b1;
            end else begin
                for (int i = NBUF - 1; i >= 0; i--) begin
                    if ((2'(i) != w_rd_cur) &&
                        !(w_latest_valid && (2'(i) == w_latest))) begin
                        w_pick  = 2'(i);
                        w_found = 1'b1;
                    end
                end
                if (!w_found) begin
                    // Only the unread frame is free: overwrite it and count
                    // the loss.
                    w_pick         = w_latest;
                    w_latest_valid = 1'b0;
                    if (w_drop_cnt != c_drop_max) begin
                        w_drop_cnt = w_drop_cnt + 16'd1;
                    end
                end
                w_wr_cur  = w_pick;
                w_wr_load = 1'b1;
                w_wr_busy = 1'b1;
                w_wr_addr = f_buf_addr(w_pick);
            end
        end
    end

    // Register the resolved state; synchronous active-low reset
    always_ff @(posedge clk_sdram) begin
        if (!rst_n) begin
            r_rd_cur       <= 2'd0;
            r_wr_cur       <= 2'd0;
            r_latest       <= 2'd0;
            r_latest_valid <= 1'b0;
            r_wr_busy      <= 1'b0;
            r_rd_busy      <= 1'b0;
            r_mem_rdy      <= 1'b0;
            r_wr_load      <= 1'b0;
            r_rd_load      <= 1'b0;
            r_wr_addr      <= BASE_ADDR;
            r_rd_addr      <= BASE_ADDR;
            r_drop_cnt     <= 16'd0;
            r_start_err    <= 1'b0;
        end else begin
            r_rd_cur       <= w_rd_cur;
            r_wr_cur       <= w_wr_cur;
            r_latest       <= w_latest;
            r_latest_valid <= w_latest_valid;
            r_wr_busy      <= w_wr_busy;
            r_rd_busy      <= w_rd_busy;
            r_mem_rdy      <= w_mem_rdy;
            r_wr_load      <= w_wr_load;
            r_rd_load      <= w_rd_load;
            r_wr_addr      <= w_wr_addr;
            r_rd_addr      <= w_rd_addr;
            r_drop_cnt     <= w_drop_cnt;
            r_start_err    <= w_start_err;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.mcb_wr_load   = r_wr_load;
    assign bus.mcb_wr_addr   = r_wr_addr;
    assign bus.mcb_wr_length = c_frame_len_m1;
    assign bus.mcb_rd_load   = r_rd_load;
    assign bus.mcb_rd_addr   = r_rd_addr;
    assign bus.mcb_rd_length = c_frame_len_m1;
    assign bus.mem_rdy       = r_mem_rdy;
    assign bus.wr_busy       = r_wr_busy;
    assign bus.rd_busy       = r_rd_busy;
    assign bus.wr_buf_idx    = r_wr_cur;
    assign bus.rd_buf_idx    = r_rd_cur;
    assign bus.drop_cnt      = r_drop_cnt;
    assign bus.start_err     = r_start_err;

endmodule
`default_nettype wire
